// File: rtl/f1_reaction_timer_pkg.sv
// Shared types and default parameters for the F1 start-light reaction timer.
package f1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LIGHTS = 2'd1,
    ST_HOLD   = 2'd2,
    ST_WAIT   = 2'd3
  } f1_state_t;

  localparam int unsigned DEF_NUM_LIGHTS = 8;
  localparam int unsigned DEF_TICK_W     = 6;
  localparam int unsigned DEF_LFSR_W     = 7;
  localparam int unsigned DEF_CNT_W      = 16;
  // x^7 + x^3 + 1, maximal length for a 7-bit register
  localparam logic [6:0]  DEF_LFSR_TAPS  = 7'b1000100;

endpackage

// File: rtl/f1_reaction_timer_if.sv
// Control, configuration and result signals between the race controller and the timer.
interface f1_reaction_timer_if
  import f1_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = DEF_NUM_LIGHTS,
  parameter int unsigned TICK_W     = DEF_TICK_W,
  parameter int unsigned LFSR_W     = DEF_LFSR_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) ();

  logic                  trigger;
  logic                  react;
  logic [TICK_W-1:0]     tick_n;
  logic                  rand_en;
  logic [LFSR_W-1:0]     fixed_k;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  busy;
  logic [CNT_W-1:0]      react_cycles;
  logic                  react_valid;
  logic                  false_start;

  modport master (
    output trigger, react, tick_n, rand_en, fixed_k,
    input  lights, busy, react_cycles, react_valid, false_start
  );

  modport slave (
    input  trigger, react, tick_n, rand_en, fixed_k,
    output lights, busy, react_cycles, react_valid, false_start
  );

endinterface

// File: rtl/f1_reaction_timer_lfsr.sv
// Free-running Fibonacci LFSR seeded with 1; a maximal-length tap mask keeps it off zero.
module lfsr_n #(
  parameter int unsigned       LFSR_W    = 7,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 7'b1000100
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= LFSR_W'(1);
    else     r_q <= {r_q[LFSR_W-2:0], w_fb};
  end

  assign q = r_q;

endmodule

// File: rtl/f1_reaction_timer.sv
// Start-light sequencer and driver reaction timer with false-start detection.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int unsigned       NUM_LIGHTS = DEF_NUM_LIGHTS,
  parameter int unsigned       TICK_W     = DEF_TICK_W,
  parameter int unsigned       LFSR_W     = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(DEF_LFSR_TAPS),
  parameter int unsigned       CNT_W      = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  f1_reaction_timer_if.slave  bus
);

  f1_state_t             r_state, w_state_nxt;
  logic [NUM_LIGHTS-1:0] r_lights, w_lights_nxt;
  logic                  r_busy;
  logic [TICK_W-1:0]     r_tick_cnt, w_tick_cnt_nxt;
  logic [TICK_W-1:0]     r_tick_n, w_tick_n_nxt;
  logic                  r_rand_en, w_rand_en_nxt;
  logic [LFSR_W-1:0]     r_fixed_k, w_fixed_k_nxt;
  logic [LFSR_W-1:0]     r_delay, w_delay_nxt;
  logic [CNT_W-1:0]      r_react_cnt, w_react_cnt_nxt;
  logic [CNT_W-1:0]      r_react_cycles, w_react_cycles_nxt;
  logic                  r_react_valid, w_react_valid_nxt;
  logic                  r_false_start, w_false_start_nxt;
  logic [LFSR_W-1:0]     w_lfsr_q;
  logic [LFSR_W-1:0]     w_k;
  logic                  w_tick;

  lfsr_n #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr_q)
  );

  assign w_tick = (r_tick_cnt == r_tick_n);
  assign w_k    = r_rand_en ? w_lfsr_q
                : ((r_fixed_k == '0) ? LFSR_W'(1) : r_fixed_k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_lights       <= '0;
      r_busy         <= 1'b0;
      r_tick_cnt     <= '0;
      r_tick_n       <= '0;
      r_rand_en      <= 1'b0;
      r_fixed_k      <= '0;
      r_delay        <= '0;
      r_react_cnt    <= '0;
      r_react_cycles <= '0;
      r_react_valid  <= 1'b0;
      r_false_start  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_lights       <= w_lights_nxt;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_tick_cnt     <= w_tick_cnt_nxt;
      r_tick_n       <= w_tick_n_nxt;
      r_rand_en      <= w_rand_en_nxt;
      r_fixed_k      <= w_fixed_k_nxt;
      r_delay        <= w_delay_nxt;
      r_react_cnt    <= w_react_cnt_nxt;
      r_react_cycles <= w_react_cycles_nxt;
      r_react_valid  <= w_react_valid_nxt;
      r_false_start  <= w_false_start_nxt;
    end
  end

  // A press during LIGHTS/HOLD is a false start and wins over a same-cycle tick
  always_comb begin
    w_state_nxt        = r_state;
    w_lights_nxt       = r_lights;
    w_tick_cnt_nxt     = r_tick_cnt;
    w_tick_n_nxt       = r_tick_n;
    w_rand_en_nxt      = r_rand_en;
    w_fixed_k_nxt      = r_fixed_k;
    w_delay_nxt        = r_delay;
    w_react_cnt_nxt    = r_react_cnt;
    w_react_cycles_nxt = r_react_cycles;
    w_react_valid_nxt  = 1'b0;
    w_false_start_nxt  = r_false_start;

    case (r_state)
      ST_IDLE: begin
        w_lights_nxt = '0;
        if (bus.trigger) begin
          w_state_nxt       = ST_LIGHTS;
          w_tick_n_nxt      = bus.tick_n;
          w_rand_en_nxt     = bus.rand_en;
          w_fixed_k_nxt     = bus.fixed_k;
          w_tick_cnt_nxt    = '0;
          w_false_start_nxt = 1'b0;
        end
      end
      ST_LIGHTS, ST_HOLD: begin
        if (bus.react) begin
          w_state_nxt       = ST_IDLE;
          w_lights_nxt      = '0;
          w_false_start_nxt = 1'b1;
        end else begin
          w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + TICK_W'(1);
          if (w_tick && (r_state == ST_LIGHTS)) begin
            w_lights_nxt = {r_lights[NUM_LIGHTS-2:0], 1'b1};
            if (r_lights[NUM_LIGHTS-2]) begin
              w_state_nxt = ST_HOLD;
              w_delay_nxt = w_k;
            end
          end else if (w_tick) begin
            if (r_delay == LFSR_W'(1)) begin
              w_state_nxt     = ST_WAIT;
              w_lights_nxt    = '0;
              w_react_cnt_nxt = '0;
            end
            w_delay_nxt = r_delay - LFSR_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (bus.react) begin
          w_state_nxt        = ST_IDLE;
          w_react_cycles_nxt = r_react_cnt;
          w_react_valid_nxt  = 1'b1;
        end else if (r_react_cnt != {CNT_W{1'b1}}) begin
          w_react_cnt_nxt = r_react_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.lights       = r_lights;
  assign bus.busy         = r_busy;
  assign bus.react_cycles = r_react_cycles;
  assign bus.react_valid  = r_react_valid;
  assign bus.false_start  = r_false_start;

endmodule

// File: doc/f1_reaction_timer.md
# f1_reaction_timer

Parametrised successor to the F1 start-light controller: sequences `NUM_LIGHTS` lamps on at a programmable tick rate, holds them lit for a random (or fixed) number of ticks, extinguishes them, then measures driver reaction time in clock cycles. Integrates the free-running LFSR, tick divider, delay counter and sequencing FSM in one block. Adds false-start detection, selectable random/fixed delay, and a saturating reaction counter. Sits at top level, driving the light bar and the score/display path.

## Interface
- `NUM_LIGHTS`, 8, number of lamps; must be ≥ 2.
- `TICK_W`, 6, width of `tick_n`.
- `LFSR_W`, 7, LFSR width; sets the random delay range 1..2^LFSR_W−1 ticks.
- `LFSR_TAPS`, 7'b1000100, feedback mask for x^7+x^3+1; must be maximal-length for `LFSR_W`.
- `CNT_W`, 16, reaction counter width.
- `clk` in 1: sole clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `trigger` in 1: start request; accepted only in IDLE.
- `react` in 1: driver button, already synchronised upstream.
- `tick_n` in TICK_W: tick period = `tick_n`+1 cycles; captured on trigger acceptance.
- `rand_en` in 1: 1 selects LFSR delay, 0 selects `fixed_k`; captured on trigger acceptance.
- `fixed_k` in LFSR_W: fixed hold delay in ticks; 0 is treated as 1.
- `lights` out NUM_LIGHTS: lamp drive; bit 0 lights first.
- `busy` out 1: state ≠ IDLE.
- `react_cycles` out CNT_W: last valid reaction time.
- `react_valid` out 1: one-cycle pulse when `react_cycles` updates.
- `false_start` out 1: sticky flag; cleared on the next accepted trigger.

## Operation
- States: IDLE, LIGHTS, HOLD, WAIT.
- **IDLE:** `lights`=0. `trigger`=1 moves the FSM to LIGHTS, latches `tick_n`/`rand_en`/`fixed_k`, clears the tick counter and clears `false_start`.
- **LIGHTS:** tick counter runs 0..`tick_n` and then wraps. On each tick, `lights` <= {`lights`[N−2:0], 1}. The tick that makes `lights` all ones also moves the FSM to HOLD and loads the delay counter with K.
- **K:** the LFSR value sampled on that same edge when `rand_en`=1; otherwise `max(fixed_k, 1)`.
- **LFSR:** free-running every cycle in all states; reset seed = 1; never reaches 0.
- **HOLD:** delay counter decrements on each tick. The tick that takes it from 1 to 0 sets `lights`=0, moves the FSM to WAIT and clears the reaction counter.
- **WAIT:** a cycle with `react`=0 increments the reaction counter, saturating at 2^CNT_W−1. A cycle with `react`=1 loads `react_cycles` with the current count, pulses `react_valid` and returns the FSM to IDLE.
- **False start:** `react`=1 in any cycle of LIGHTS or HOLD sets `lights`=0 and `false_start`=1, returns the FSM to IDLE and does not pulse `react_valid`. This takes priority over a tick in the same cycle.
- `trigger` while busy is ignored. In IDLE, `react` is ignored, including when it coincides with `trigger`.
- No timeout: WAIT persists until `react` or `rst`.

## Timing
- Reset values: state=IDLE, `lights`=0, `busy`=0, `react_cycles`=0, `react_valid`=0, `false_start`=0, LFSR=1, all counters 0.
- Trigger seen at edge t: `busy`=1 after t.
- Light i (1-based) turns on at edge t + i·(`tick_n`+1).
- All lights are on at edge t + N·(`tick_n`+1); lights go off exactly K·(`tick_n`+1) cycles later.
- WAIT cycle index 0 is the first cycle with lights off. `react` sampled high in WAIT cycle j gives `react_cycles`=j and `react_valid` on the following cycle, with `busy`=0 on that same cycle.
- A new trigger is accepted on the first cycle after the return to IDLE.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous); no result is reported.

## Structure
- Package `f1_pkg`: state enum `f1_state_t`, default parameter constants, LFSR_TAPS default.
- Sub-module `lfsr_n` (parameters `LFSR_W`, `LFSR_TAPS`; ports `clk`, `rst`, `q`). All other logic lives in a single FSM/counter module.

## Test plan
- `tick_n`=2, `rand_en`=0, `fixed_k`=4, pulse `trigger` at t → `lights` = 01, 03, … FF at edges t+3 … t+24; `lights`=0 at t+36; `busy`=1 throughout.
- Same run, `react` high in WAIT cycle 10 → `react_cycles`=10, one-cycle `react_valid`, `busy`=0.
- `react` pulsed when `lights`=07 → `lights`=0 and `false_start`=1 on the next cycle, no `react_valid`; the next trigger clears `false_start`.
- `fixed_k`=0 → hold lasts exactly 1 tick (3 cycles at `tick_n`=2). `tick_n`=0 → one light per cycle.
- `rand_en`=1, 20 back-to-back runs → every hold length is K·(`tick_n`+1) with K in 1..127, matching a reference LFSR model, with at least 2 distinct K values.
- `CNT_W`=4, no `react` for 30 WAIT cycles then `react` → `react_cycles`=15. `rst` asserted mid-HOLD → immediate reset values; `trigger` during HOLD has no effect.
